// File: rtl/tlk2711_chan_hub_if.sv
// Upstream PS register bus between the host and tlk2711_chan_hub.
// The host drives one-cycle write/read strobes; the hub answers every read with a one-cycle rvalid.
interface tlk2711_chan_hub_if;
    logic        i_reg_wen;
    logic [15:0] i_reg_waddr;
    logic [63:0] i_reg_wdata;
    logic        i_reg_ren;
    logic [15:0] i_reg_raddr;
    logic [63:0] o_reg_rdata;
    logic        o_reg_rvalid;

    modport master (
        output i_reg_wen, i_reg_waddr, i_reg_wdata, i_reg_ren, i_reg_raddr,
        input  o_reg_rdata, o_reg_rvalid
    );

    modport slave (
        input  i_reg_wen, i_reg_waddr, i_reg_wdata, i_reg_ren, i_reg_raddr,
        output o_reg_rdata, o_reg_rvalid
    );
endinterface

// File: rtl/tlk2711_chan_hub.sv
// Register-bus decode, pipelined read return and interrupt aggregation for NUM_CH tlk2711 channels.
// Optional cycle timestamp of the last interrupt: define TLK_HUB_TIMESTAMP_EN.
module tlk2711_chan_hub #(
    parameter int NUM_CH      = 2,
    parameter int CH_SHIFT    = 8,
    parameter int CH_BASE_IDX = 0,
    parameter int HUB_IDX     = 8'h0F,
    parameter int RD_LATENCY  = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    tlk2711_chan_hub_if.slave      bus,
    output logic [NUM_CH-1:0]      o_ch_reg_wen,
    output logic [15:0]            o_ch_reg_waddr,
    output logic [63:0]            o_ch_reg_wdata,
    output logic [NUM_CH-1:0]      o_ch_reg_ren,
    output logic [15:0]            o_ch_reg_raddr,
    input  logic [64*NUM_CH-1:0]   i_ch_reg_rdata,
    input  logic [3*NUM_CH-1:0]    i_ch_irq,
    output logic                   o_irq
);

    localparam int              NI       = 3 * NUM_CH;
    localparam int              IW       = 16 - CH_SHIFT;
    localparam logic [15:0]     OFF_MASK = 16'((32'd1 << CH_SHIFT) - 32'd1);
    localparam logic [IW-1:0]   HUB_SEL  = IW'(HUB_IDX);
    localparam logic [63:0]     HUB_ID   = {32'h2711_4855, 16'd0, 8'd0, 8'(NUM_CH)};

    generate
        if (NUM_CH < 1 || NUM_CH > 16) begin : g_bad_num_ch
            $error("tlk2711_chan_hub: NUM_CH must be 1..16");
        end
        if (RD_LATENCY < 1 || RD_LATENCY > 4) begin : g_bad_latency
            $error("tlk2711_chan_hub: RD_LATENCY must be 1..4");
        end
        if (HUB_IDX >= CH_BASE_IDX && HUB_IDX < CH_BASE_IDX + NUM_CH) begin : g_hub_overlap
            $error("tlk2711_chan_hub: HUB_IDX overlaps the channel windows");
        end
    endgenerate

    typedef enum logic [1:0] {T_NONE, T_CH, T_HUB} tgt_t;

    typedef struct packed {
        logic        valid;
        tgt_t        tgt;
        logic [3:0]  ch;
        logic [63:0] hub_data;
    } rd_ent_t;

    function automatic logic ch_hit(input logic [15:0] a);
        int rel;
        rel = int'(a[15:CH_SHIFT]) - CH_BASE_IDX;
        return (rel >= 0) && (rel < NUM_CH);
    endfunction

    function automatic logic [3:0] ch_num(input logic [15:0] a);
        int rel;
        rel = int'(a[15:CH_SHIFT]) - CH_BASE_IDX;
        return 4'(rel);
    endfunction

    logic          w_ch_hit, w_hub_hit, r_ch_hit, r_hub_hit, hub_w;
    logic [3:0]    w_ch, r_ch;
    logic [15:0]   w_off, r_off;
    logic [NUM_CH-1:0] wen_next, ren_next;
    logic [63:0]   hub_rdata, rd_sel;
    logic [NI-1:0] pending, enable, irq_hist, rise, clr;
    rd_ent_t       new_ent;
    rd_ent_t       rd_pipe [RD_LATENCY+1];
`ifdef TLK_HUB_TIMESTAMP_EN
    logic [31:0]   cnt, last_ts;
`endif

    assign w_ch_hit  = ch_hit(bus.i_reg_waddr);
    assign r_ch_hit  = ch_hit(bus.i_reg_raddr);
    assign w_ch      = ch_num(bus.i_reg_waddr);
    assign r_ch      = ch_num(bus.i_reg_raddr);
    assign w_hub_hit = (bus.i_reg_waddr[15:CH_SHIFT] == HUB_SEL);
    assign r_hub_hit = (bus.i_reg_raddr[15:CH_SHIFT] == HUB_SEL);
    assign w_off     = bus.i_reg_waddr & OFF_MASK;
    assign r_off     = bus.i_reg_raddr & OFF_MASK;
    assign hub_w     = bus.i_reg_wen && w_hub_hit;
    assign rise      = i_ch_irq & ~irq_hist;

    always_comb begin
        wen_next = '0;
        ren_next = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (bus.i_reg_wen && w_ch_hit && w_ch == 4'(k)) wen_next[k] = 1'b1;
            if (bus.i_reg_ren && r_ch_hit && r_ch == 4'(k)) ren_next[k] = 1'b1;
        end
    end

    // Clear and set are resolved in one expression below, so a same-cycle edge wins.
    always_comb begin
        clr = '0;
        if (hub_w && w_off == 16'h0010) clr = bus.i_reg_wdata[NI-1:0];
    end

    always_comb begin
        hub_rdata = '0;
        case (r_off)
            16'h0000: hub_rdata[NI-1:0] = pending;
            16'h0008: hub_rdata[NI-1:0] = enable;
            16'h0018: hub_rdata = HUB_ID;
`ifdef TLK_HUB_TIMESTAMP_EN
            16'h0020: hub_rdata = {32'd0, last_ts};
            16'h0028: hub_rdata = {32'd0, cnt};
`endif
            default:  hub_rdata = '0;
        endcase
    end

    always_comb begin
        new_ent          = '0;
        new_ent.valid    = bus.i_reg_ren;
        new_ent.ch       = r_ch;
        new_ent.hub_data = hub_rdata;
        if (r_ch_hit)       new_ent.tgt = T_CH;
        else if (r_hub_hit) new_ent.tgt = T_HUB;
        else                new_ent.tgt = T_NONE;
    end

    // Channel data is selected by index rather than ORed, so idle channels may drive anything.
    always_comb begin
        rd_sel = '0;
        if (rd_pipe[RD_LATENCY].valid) begin
            case (rd_pipe[RD_LATENCY].tgt)
                T_CH: begin
                    for (int k = 0; k < NUM_CH; k++) begin
                        if (rd_pipe[RD_LATENCY].ch == 4'(k)) rd_sel = i_ch_reg_rdata[64*k +: 64];
                    end
                end
                T_HUB:   rd_sel = rd_pipe[RD_LATENCY].hub_data;
                default: rd_sel = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            o_ch_reg_wen     <= '0;
            o_ch_reg_waddr   <= '0;
            o_ch_reg_wdata   <= '0;
            o_ch_reg_ren     <= '0;
            o_ch_reg_raddr   <= '0;
            bus.o_reg_rvalid <= 1'b0;
            bus.o_reg_rdata  <= '0;
            for (int i = 0; i <= RD_LATENCY; i++) rd_pipe[i] <= '0;
            pending          <= '0;
            enable           <= '0;
            irq_hist         <= i_ch_irq;
            o_irq            <= 1'b0;
`ifdef TLK_HUB_TIMESTAMP_EN
            cnt              <= '0;
            last_ts          <= '0;
`endif
        end else begin
            o_ch_reg_wen     <= wen_next;
            o_ch_reg_waddr   <= w_off;
            o_ch_reg_wdata   <= bus.i_reg_wdata;
            o_ch_reg_ren     <= ren_next;
            o_ch_reg_raddr   <= r_off;
            rd_pipe[0]       <= new_ent;
            for (int i = 1; i <= RD_LATENCY; i++) rd_pipe[i] <= rd_pipe[i-1];
            bus.o_reg_rvalid <= rd_pipe[RD_LATENCY].valid;
            bus.o_reg_rdata  <= rd_sel;
            irq_hist         <= i_ch_irq;
            pending          <= (pending & ~clr) | rise;
            if (hub_w && w_off == 16'h0008) enable <= bus.i_reg_wdata[NI-1:0];
            o_irq            <= |(pending & enable);
`ifdef TLK_HUB_TIMESTAMP_EN
            cnt              <= cnt + 32'd1;
            if (|rise) last_ts <= cnt;
`endif
        end
    end

endmodule

// File: tb/tb_tlk2711_chan_hub.sv
// Self-checking bench for tlk2711_chan_hub with NUM_CH=4 and RD_LATENCY=2.
// Read returns are checked against an expected-data/expected-cycle scoreboard.
module tb_tlk2711_chan_hub;

    localparam int NUM_CH = 4;
    localparam int RD_LAT = 2;
    localparam int NI     = 3 * NUM_CH;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    tlk2711_chan_hub_if bus();

    logic [NUM_CH-1:0]    ch_wen, ch_ren;
    logic [15:0]          ch_waddr, ch_raddr;
    logic [63:0]          ch_wdata;
    logic [64*NUM_CH-1:0] ch_rdata;
    logic [NI-1:0]        ch_irq;
    logic                 irq;

    tlk2711_chan_hub #(
        .NUM_CH(NUM_CH), .CH_SHIFT(8), .CH_BASE_IDX(0), .HUB_IDX(8'h0F), .RD_LATENCY(RD_LAT)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .o_ch_reg_wen(ch_wen), .o_ch_reg_waddr(ch_waddr), .o_ch_reg_wdata(ch_wdata),
        .o_ch_reg_ren(ch_ren), .o_ch_reg_raddr(ch_raddr), .i_ch_reg_rdata(ch_rdata),
        .i_ch_irq(ch_irq), .o_irq(irq)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Channel model: data is only correct exactly RD_LAT cycles after its read strobe.
    logic [1:0]  lat_sr [NUM_CH];
    logic [63:0] ch_data [NUM_CH];
    always @(posedge clk) begin
        for (int k = 0; k < NUM_CH; k++) begin
            if (rst) lat_sr[k] <= 2'b00;
            else     lat_sr[k] <= {lat_sr[k][0], ch_ren[k]};
        end
    end
    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch_model
        assign ch_rdata[64*g +: 64] = lat_sr[g][1] ? ch_data[g] : (64'hDEAD_0000_0000_0000 | 64'(g));
    end

    logic [63:0] exp_q[$];
    int          exp_t_q[$];
    int          checks = 0;
    int          failures = 0;
    int          rel_cyc = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [15:0] a, input logic [63:0] d);
        bus.i_reg_wen   = 1'b1;
        bus.i_reg_waddr = a;
        bus.i_reg_wdata = d;
        tick();
        bus.i_reg_wen   = 1'b0;
    endtask

    task automatic do_read(input logic [15:0] a, input logic [63:0] exp);
        bus.i_reg_ren   = 1'b1;
        bus.i_reg_raddr = a;
        exp_q.push_back(exp);
        exp_t_q.push_back(cyc + 2 + RD_LAT);
        tick();
        bus.i_reg_ren   = 1'b0;
    endtask

    task automatic drain(input string name);
        int budget;
        int extra;
        logic [63:0] d;
        int t;
        budget = 30;
        while (exp_q.size() > 0 && budget > 0) begin
            @(negedge clk);
            budget--;
            if (bus.o_reg_rvalid) begin
                d = exp_q.pop_front();
                t = exp_t_q.pop_front();
                checks++;
                if (bus.o_reg_rdata !== d || cyc != t) begin
                    failures++;
                    $display("FAIL %s_read got=%h @%0d exp=%h @%0d", name, bus.o_reg_rdata, cyc, d, t);
                end
            end
        end
        if (exp_q.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout got=%0d outstanding exp=0", name, exp_q.size());
            exp_q.delete();
            exp_t_q.delete();
        end
        extra = 0;
        repeat (4) begin
            @(negedge clk);
            if (bus.o_reg_rvalid) extra++;
        end
        checks++;
        if (extra != 0) begin
            failures++;
            $display("FAIL %s_extra_rvalid got=%0d exp=0", name, extra);
        end
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.i_reg_wen = 1'b0; bus.i_reg_ren = 1'b0;
        bus.i_reg_waddr = '0; bus.i_reg_raddr = '0; bus.i_reg_wdata = '0;
        ch_irq = '0;
        repeat (3) tick();
        checks++;
        if ({irq, bus.o_reg_rvalid, ch_wen, ch_ren} !== '0 || bus.o_reg_rdata !== 64'd0) begin
            failures++;
            $display("FAIL reset_outputs got=%b/%b/%b/%b/%h exp=0", irq, bus.o_reg_rvalid, ch_wen, ch_ren, bus.o_reg_rdata);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_write();
        do_write(16'h0310, 64'hA5);
        checks++;
        if (ch_wen !== 4'b1000 || ch_waddr !== 16'h0010 || ch_wdata !== 64'hA5) begin
            failures++;
            $display("FAIL write_ch3 got=%b/%h/%h exp=1000/0010/a5", ch_wen, ch_waddr, ch_wdata);
        end
        tick();
        checks++;
        if (ch_wen !== 4'b0000) begin
            failures++;
            $display("FAIL write_strobe_len got=%b exp=0000", ch_wen);
        end
        do_write(16'h0500, 64'h5A);
        checks++;
        if (ch_wen !== 4'b0000) begin
            failures++;
            $display("FAIL write_unmapped got=%b exp=0000", ch_wen);
        end
        do_write(16'h00F8, 64'h1234_5678_9ABC_DEF0);
        checks++;
        if (ch_wen !== 4'b0001 || ch_waddr !== 16'h00F8 || ch_wdata !== 64'h1234_5678_9ABC_DEF0) begin
            failures++;
            $display("FAIL write_ch0 got=%b/%h/%h exp=0001/00f8/123456789abcdef0", ch_wen, ch_waddr, ch_wdata);
        end
        tick();
    endtask

    task automatic test_read();
        do_read(16'h0008, ch_data[0]);
        checks++;
        if (ch_ren !== 4'b0001 || ch_raddr !== 16'h0008) begin
            failures++;
            $display("FAIL read_strobe got=%b/%h exp=0001/0008", ch_ren, ch_raddr);
        end
        do_read(16'h0108, ch_data[1]);
        do_read(16'h0700, 64'd0);
        drain("b2b");
        do_read(16'h0F18, 64'h2711_4855_0000_0004);
        do_read(16'h0300, ch_data[3]);
        do_read(16'h0F38, 64'd0);
        drain("hub_id");
    endtask

    task automatic test_irq();
        ch_irq[4] = 1'b1; tick();
        ch_irq[4] = 1'b0; tick();
        checks++;
        if (irq !== 1'b0) begin
            failures++;
            $display("FAIL irq_masked got=%b exp=0", irq);
        end
        do_read(16'h0F00, 64'h10);
        drain("pending_set");
        do_write(16'h0F08, 64'h10);
        checks++;
        if (irq !== 1'b0) begin
            failures++;
            $display("FAIL irq_en_early got=%b exp=0", irq);
        end
        tick();
        checks++;
        if (irq !== 1'b1) begin
            failures++;
            $display("FAIL irq_en_on got=%b exp=1", irq);
        end
        do_read(16'h0F08, 64'h10);
        do_read(16'h0F10, 64'd0);
        drain("enable_rd");
        do_write(16'h0F10, 64'h10);
        checks++;
        if (irq !== 1'b1) begin
            failures++;
            $display("FAIL irq_clr_early got=%b exp=1", irq);
        end
        tick();
        checks++;
        if (irq !== 1'b0) begin
            failures++;
            $display("FAIL irq_clr_off got=%b exp=0", irq);
        end
        do_read(16'h0F00, 64'd0);
        drain("pending_clr");
        do_write(16'h0F08, 64'hFFFF_FFFF_FFFF_FFFF);
        do_read(16'h0F08, 64'hFFF);
        drain("enable_mask");
        do_write(16'h0F08, 64'h10);
        tick();
    endtask

    task automatic test_set_wins();
        ch_irq[4] = 1'b1; tick();
        ch_irq[4] = 1'b0; tick();
        ch_irq[4] = 1'b1;
        do_write(16'h0F10, 64'h10);
        do_read(16'h0F00, 64'h10);
        drain("set_wins");
        checks++;
        if (irq !== 1'b1) begin
            failures++;
            $display("FAIL set_wins_irq got=%b exp=1", irq);
        end
        do_write(16'h0F10, 64'h10);
        tick();
        checks++;
        if (irq !== 1'b0) begin
            failures++;
            $display("FAIL level_no_reset_irq got=%b exp=0", irq);
        end
        do_read(16'h0F00, 64'd0);
        drain("level_held");
        ch_irq[4] = 1'b0;
        tick();
    endtask

    task automatic test_reset_irq();
        int seen;
        ch_irq[2] = 1'b1; tick();
        rst = 1'b1; tick(); tick();
        rst = 1'b0; tick();
        do_read(16'h0F00, 64'd0);
        do_read(16'h0F08, 64'd0);
        drain("held_across_rst");
        ch_irq[2] = 1'b0; tick();
        ch_irq[2] = 1'b1; tick();
        do_read(16'h0F00, 64'h4);
        drain("retoggle");
        bus.i_reg_ren   = 1'b1;
        bus.i_reg_raddr = 16'h0108;
        tick();
        bus.i_reg_ren = 1'b0;
        rst = 1'b1; tick(); tick();
        rst = 1'b0;
        rel_cyc = cyc;
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (bus.o_reg_rvalid) seen++;
        end
        checks++;
        if (seen != 0) begin
            failures++;
            $display("FAIL rst_mid_read got=%0d rvalid exp=0", seen);
        end
        tick();
    endtask

    task automatic test_timestamp();
        int rise_cyc;
        ch_irq[0] = 1'b1;
        rise_cyc = cyc;
        tick();
        tick();
`ifdef TLK_HUB_TIMESTAMP_EN
        do_read(16'h0F20, 64'(rise_cyc - rel_cyc));
        do_read(16'h0F28, 64'(cyc - rel_cyc));
`else
        do_read(16'h0F20, 64'd0);
        do_read(16'h0F28, 64'd0);
`endif
        drain("timestamp");
        ch_irq[0] = 1'b0;
        tick();
    endtask

    initial begin
        for (int k = 0; k < NUM_CH; k++) ch_data[k] = 64'h11 * 64'(k + 1);
        test_reset();
        test_write();
        test_read();
        test_irq();
        test_set_wins();
        test_reset_irq();
        test_timestamp();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/tlk2711_chan_hub.md
Name: tlk2711_chan_hub

Overview:
Parametrised register-bus and interrupt hub for NUM_CH tlk2711_top channels. It replaces the fixed two-instance mask/base decode and read-data OR with three pieces:
- a registered, index-based address decoder;
- a pipelined read-return path with a valid strobe;
- a central interrupt pending/enable/clear block that folds all 3*NUM_CH channel interrupts into one PS interrupt line.

The hub sits between the PS register bus and the channel instances, in the clk domain.

Parameters:
NUM_CH, 2, number of TLK2711 channels, 1..16.
CH_SHIFT, 8, log2 of the per-channel address window (window = 256 bytes).
CH_BASE_IDX, 0, value of addr[15:CH_SHIFT] that selects channel 0.
HUB_IDX, 8'h0F, value of addr[15:CH_SHIFT] that selects the hub's own registers.
RD_LATENCY, 1, channel read latency in cycles from o_ch_reg_ren to valid i_ch_reg_rdata, 1..4.

Ports:
clk  in  1  clock; all logic is in this domain.
rst  in  1  synchronous reset, active-high.
i_reg_wen  in  1  upstream write strobe.
i_reg_waddr  in  16  upstream write byte address.
i_reg_wdata  in  64  upstream write data.
i_reg_ren  in  1  upstream read strobe.
i_reg_raddr  in  16  upstream read byte address.
o_reg_rdata  out  64  read return data.
o_reg_rvalid  out  1  one-cycle read-return strobe.
o_ch_reg_wen  out  NUM_CH  per-channel write strobe (one-hot or zero).
o_ch_reg_waddr  out  16  window offset, addr & ((1<<CH_SHIFT)-1).
o_ch_reg_wdata  out  64  registered write data.
o_ch_reg_ren  out  NUM_CH  per-channel read strobe (one-hot or zero).
o_ch_reg_raddr  out  16  read window offset.
i_ch_reg_rdata  in  64*NUM_CH  channel read data; channel k occupies [64k+63:64k].
i_ch_irq  in  3*NUM_CH  per-channel interrupts; channel k: bit 3k = tx, 3k+1 = rx, 3k+2 = loss.
o_irq  out  1  aggregated level interrupt.

Behaviour:
Reset:
- All outputs 0; pending, enable and the read pipeline are cleared.
- The irq edge-detect history is loaded with the current i_ch_irq, so no spurious pending bits are set on exit from reset.
- A reset mid-read drops any in-flight read; no rvalid is produced for it.

Address decode:
- idx = addr[15:CH_SHIFT].
- Channel k is hit when idx == CH_BASE_IDX+k and k < NUM_CH.
- The hub is hit when idx == HUB_IDX. A HUB_IDX that falls in the channel range is illegal (elaboration error).

Write path:
- 1-cycle registered pass-through: wen/waddr/wdata in cycle N appear on the channel outputs in cycle N+1.
- Writes to unmapped addresses are dropped.
- Hub writes take effect in cycle N+1.

Read path:
- ren in cycle N produces o_ch_reg_ren in cycle N+1.
- The registered target (channel index, hub, or unmapped) is delayed RD_LATENCY cycles in a shift pipeline. rdata is muxed from the selected channel (not ORed) and registered.
- o_reg_rvalid = 1 at cycle N+2+RD_LATENCY, for exactly one cycle.
- Hub reads follow the same latency.
- Unmapped reads return 0 with rvalid.
- Back-to-back reads, one per cycle, are fully pipelined and returned in order.
- Simultaneous wen and ren are both serviced.

Hub registers (offset within the hub window):
- 0x00 IRQ_PENDING, RO. 3*NUM_CH bits, zero-extended to 64.
- 0x08 IRQ_ENABLE, RW. Reset value 0. Bits at or above 3*NUM_CH are ignored on write and read as 0.
- 0x10 IRQ_CLEAR, write-1-to-clear of pending bits. Reads as 0.
- 0x18 HUB_ID, RO. {32'h2711_4855, 16'd0, 8'd0, NUM_CH[7:0]}.
- Any other offset reads 0.

Interrupt logic:
- A rising edge on i_ch_irq[b] sets pending[b] the next cycle.
- If a set and a clear of the same bit occur in the same cycle, the set wins.
- A level held high does not re-set a bit after it is cleared.
- o_irq is registered: o_irq = |(pending & enable), one cycle after the pending/enable update.

Optional Feature:
Macro: TLK_HUB_TIMESTAMP_EN.

With the macro defined:
- Free-running 32-bit cycle counter, cleared by rst, wraps from 0xFFFFFFFF to 0.
- On any cycle where at least one pending bit is set, the counter value is latched into LAST_IRQ_TS.
- Hub offset 0x20 reads {32'd0, LAST_IRQ_TS}.
- Offset 0x28 is the live counter.

Without the macro:
- No counter logic.
- Offsets 0x20 and 0x28 read 0.

Test Plan:
1. NUM_CH=4, write addr 0x0310 data 0xA5 -> next cycle o_ch_reg_wen = 4'b1000, o_ch_reg_waddr = 0x0010, o_ch_reg_wdata = 0xA5; write to 0x0500 -> no strobe.
2. RD_LATENCY=2, reads of 0x0008 then 0x0108 in consecutive cycles, ch0 returns 0x11, ch1 returns 0x22 -> rvalid in cycles N+4 and N+5 carrying 0x11 then 0x22; read of 0x0700 -> rvalid with data 0.
3. Pulse ch1 rx irq (bit 4) with enable = 0 -> IRQ_PENDING = 0x10, o_irq = 0; write IRQ_ENABLE = 0x10 -> o_irq = 1 two cycles after the write strobe; write IRQ_CLEAR = 0x10 -> pending 0, o_irq = 0.
4. Assert a new rising edge on bit 4 in the same cycle as the W1C write of 0x10 takes effect -> pending[4] stays 1.
5. Hold bit 2 high across reset -> pending = 0 after reset; later toggle 0→1 -> pending = 0x4. Assert rst while a read is in flight -> no rvalid.
6. TLK_HUB_TIMESTAMP_EN defined, irq edge at counter value 1000 -> offset 0x20 reads 1000 (±1 for register stage); undefined -> offset 0x20 reads 0.
